// File: rtl/bmp_crop_sched.sv
// bmp_crop_sched: sequences header writer and per-row copier for a cropped BMP and owns the output write port
// Ports: clk, rst_n (sync, active-low); start + xMin/xMax/yMin/yMax latch the crop window;
// done/err report completion; hdr_start/hdr_done/hdr_* drive and mux the header writer;
// row_start/row_y/row_done/row_* drive and mux the row copier; addr/wren/wrdata is the byte-addressed output port.
module bmp_crop_sched #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic        done,
  output logic        err,
  output logic        hdr_start,
  input  logic        hdr_done,
  input  logic [23:0] hdr_addr,
  input  logic        hdr_wren,
  input  logic [15:0] hdr_wrdata,
  output logic        row_start,
  output logic [10:0] row_y,
  input  logic        row_done,
  input  logic [12:0] row_addr,
  input  logic        row_wren,
  input  logic [15:0] row_wrdata,
  output logic [23:0] addr,
  output logic        wren,
  output logic [15:0] wrdata
);
  typedef enum logic [2:0] {IDLE, HDR_GO, HDR_WAIT, ROW_GO, ROW_WAIT, PAD, NEXT, DONE} state_t;
  localparam logic [11:0] W_LIM = 12'(WIDTH);
  localparam logic [11:0] H_LIM = 12'(HEIGHT);
  state_t state, state_nx;
  logic [10:0] x_min, x_max, y_min, w;
  logic [12:0] rw, pw;
  logic [1:0] pad, k;
  logic [23:0] base;
  logic err_r, hdr_first, go, bad;
  assign go  = start && (state == IDLE || state == DONE);
  assign bad = (xMax < xMin) || (yMax < yMin) || ({1'b0, xMax} >= W_LIM) || ({1'b0, yMax} >= H_LIM);
  assign w   = x_max - x_min + 11'd1;
  assign rw  = {2'd0, w} * 13'd3;
  // padding to a 4-byte multiple is just the two's complement of rw mod 4
  assign pad = 2'd0 - rw[1:0];
  assign pw  = rw + {11'd0, pad};
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    done      = state == DONE;
    err       = err_r && state == DONE;
    hdr_start = state == HDR_GO;
    row_start = state == ROW_GO;
    addr      = 24'd0;
    wren      = 1'b0;
    wrdata    = 16'd0;
    case (state)
      IDLE, DONE: if (start) state_nx = bad ? DONE : HDR_GO;
      HDR_GO:     state_nx = HDR_WAIT;
      HDR_WAIT: begin
        // hdr_done is a level left over from the previous run during the first wait cycle
        if (!hdr_first && hdr_done) state_nx = ROW_GO;
        addr   = hdr_addr;
        wren   = hdr_wren;
        wrdata = hdr_wrdata;
      end
      ROW_GO:     state_nx = ROW_WAIT;
      ROW_WAIT: begin
        if (row_done) state_nx = pad != 2'd0 ? PAD : NEXT;
        addr   = base + {11'd0, row_addr};
        wren   = row_wren;
        wrdata = row_wrdata;
      end
      PAD: begin
        if (k == pad - 2'd1) state_nx = NEXT;
        addr = base + {11'd0, rw} + {22'd0, k};
        wren = 1'b1;
      end
      NEXT:       state_nx = row_y == y_min ? DONE : ROW_GO;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      x_min     <= 11'd0;
      x_max     <= 11'd0;
      y_min     <= 11'd0;
      row_y     <= 11'd0;
      base      <= 24'd54;
      err_r     <= 1'b0;
      hdr_first <= 1'b0;
      k         <= 2'd0;
    end else begin
      hdr_first <= state == HDR_GO;
      k         <= state == PAD ? k + 2'd1 : 2'd0;
      if (go) begin
        x_min <= xMin;
        x_max <= xMax;
        y_min <= yMin;
        row_y <= yMax;
        base  <= 24'd54;
        err_r <= bad;
      end else if (state == NEXT) begin
        base <= base + {11'd0, pw};
        if (row_y != y_min) row_y <= row_y - 11'd1;
      end
    end
endmodule
